// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types for the memory dump engine and Intel-HEX helpers.
// Holds the dump FSM encoding and the record constants.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        EMIT,
        EOF,
        DONE
    } dump_state_t;

    localparam logic [7:0] IHEX_DATA_LEN   = 8'h04;
    localparam logic [7:0] IHEX_EOF_CHKSUM = 8'hFF;

    typedef struct packed {
        logic [15:0] index;
        word_t       data;
        logic [7:0]  chksum;
    } ihex_rec_t;

endpackage

// File: rtl/ihex_checksum.sv
// Intel-HEX checksum of a 4-byte data record at a 16-bit word index.
// Two's complement of the byte sum, record type 00.
module ihex_checksum
    import cpu_types_pkg::*;
(
    input  logic [15:0] index,
    input  word_t       data,
    output logic [7:0]  chksum
);

    logic [10:0] sum;

    always_comb begin
        sum = 11'(IHEX_DATA_LEN)
            + 11'(index[15:8])
            + 11'(index[7:0])
            + 11'(data[31:24])
            + 11'(data[23:16])
            + 11'(data[15:8])
            + 11'(data[7:0]);
        chksum = 8'(11'h100 - sum);
    end

endmodule

// File: rtl/mem_dump_engine.sv
// Walks memory through the caches_if data port and streams every
// (non-zero) word as an Intel-HEX data record, then one EOF record.
module mem_dump_engine
    import cpu_types_pkg::*;
#(
    parameter int WORDS     = 16384,
    parameter bit SKIP_ZERO = 1'b1
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        dREN,
    output logic        dWEN,
    output word_t       daddr,
    output word_t       dstore,
    input  logic        dwait,
    input  word_t       dload,
    output logic        rec_valid,
    input  logic        rec_ready,
    output logic        rec_last,
    output logic [15:0] rec_index,
    output word_t       rec_data,
    output logic [7:0]  rec_chksum
);

    localparam logic [15:0] LAST_IDX = 16'(WORDS - 1);

    localparam ihex_rec_t EOF_REC = '{
        index:  16'h0000,
        data:   32'h0000_0000,
        chksum: IHEX_EOF_CHKSUM
    };

    dump_state_t state_q, state_d;
    logic [15:0] idx_q, idx_d;
    ihex_rec_t   rec_q, rec_d;
    logic [7:0]  ck;
    logic        last_word;

    ihex_checksum u_ck (
        .index  (idx_q),
        .data   (dload),
        .chksum (ck)
    );

    assign last_word = (idx_q == LAST_IDX);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            idx_q   <= '0;
            rec_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rec_q   <= rec_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rec_d   = rec_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = REQ;
                    idx_d   = '0;
                end
            end
            REQ: begin
                if (!dwait) begin
                    if (SKIP_ZERO && (dload == '0)) begin
                        if (last_word) begin
                            state_d = EOF;
                            rec_d   = EOF_REC;
                        end else begin
                            idx_d = idx_q + 16'd1;
                        end
                    end else begin
                        state_d      = EMIT;
                        rec_d.index  = idx_q;
                        rec_d.data   = dload;
                        rec_d.chksum = ck;
                    end
                end
            end
            EMIT: begin
                if (rec_ready) begin
                    if (last_word) begin
                        state_d = EOF;
                        rec_d   = EOF_REC;
                    end else begin
                        state_d = REQ;
                        idx_d   = idx_q + 16'd1;
                    end
                end
            end
            EOF: begin
                if (rec_ready) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // All outputs decode straight from registered state.
    assign dREN       = (state_q == REQ);
    assign dWEN       = 1'b0;
    assign dstore     = '0;
    assign daddr      = dREN ? {14'b0, idx_q, 2'b00} : '0;
    assign rec_valid  = (state_q == EMIT) || (state_q == EOF);
    assign rec_last   = (state_q == EOF);
    assign rec_index  = rec_q.index;
    assign rec_data   = rec_q.data;
    assign rec_chksum = rec_q.chksum;
    assign busy       = (state_q == REQ) || (state_q == EMIT)
                     || (state_q == EOF);
    assign done       = (state_q == DONE);

endmodule

// File: tb/tb_mem_dump_engine.sv
// Directed bench for mem_dump_engine: table of memory images with
// hand-computed record streams plus stall, reset and restart sequences.
module tb_mem_dump_engine;

    typedef struct packed {
        logic        last;
        logic [15:0] idx;
        logic [31:0] data;
        logic [7:0]  ck;
    } rec_t;

    typedef struct packed {
        logic [0:3][31:0] mem;
        logic [3:0]       wait_n;
        logic [2:0]       n;
        rec_t [0:4]       exp;
    } vec_t;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        start, rdy;
    logic        busy, done, dREN, dWEN, dwait, rec_valid, rec_last;
    logic [31:0] daddr, dstore, dload, rec_data;
    logic [15:0] rec_index;
    logic [7:0]  rec_chksum;

    logic        start2;
    logic        busy2, done2, dREN2, dWEN2, rec_valid2, rec_last2;
    logic [31:0] daddr2, dstore2, rec_data2;
    logic [15:0] rec_index2;
    logic [7:0]  rec_chksum2;

    logic [0:3][31:0] mem;
    int          wait_n = 0;
    int          cnt = 0;
    int          checks = 0;
    int          fails = 0;
    int          done_cnt = 0;
    int          viol = 0;
    rec_t        got[$];
    rec_t        got2[$];
    vec_t        tbl[6];

    always #5 CLK = ~CLK;

    mem_dump_engine #(.WORDS(4), .SKIP_ZERO(1'b1)) dut (
        .CLK(CLK), .nRST(nRST), .start(start), .busy(busy),
        .done(done), .dREN(dREN), .dWEN(dWEN), .daddr(daddr),
        .dstore(dstore), .dwait(dwait), .dload(dload),
        .rec_valid(rec_valid), .rec_ready(rdy),
        .rec_last(rec_last), .rec_index(rec_index),
        .rec_data(rec_data), .rec_chksum(rec_chksum)
    );

    mem_dump_engine #(.WORDS(2), .SKIP_ZERO(1'b0)) dut2 (
        .CLK(CLK), .nRST(nRST), .start(start2), .busy(busy2),
        .done(done2), .dREN(dREN2), .dWEN(dWEN2), .daddr(daddr2),
        .dstore(dstore2), .dwait(1'b0), .dload(32'h0),
        .rec_valid(rec_valid2), .rec_ready(1'b1),
        .rec_last(rec_last2), .rec_index(rec_index2),
        .rec_data(rec_data2), .rec_chksum(rec_chksum2)
    );

    // Memory controller: wait_n busy cycles before each read returns.
    always @(posedge CLK)
        if (!dREN || !dwait) cnt <= 0;
        else cnt <= cnt + 1;
    assign dwait = dREN && (cnt < wait_n);
    assign dload = dwait ? 32'hDEADBEEF : mem[daddr[3:2]];

    always @(posedge CLK) begin
        if (nRST && rec_valid && rdy)
            got.push_back({rec_last, rec_index, rec_data, rec_chksum});
        if (nRST && rec_valid2)
            got2.push_back({rec_last2, rec_index2, rec_data2, rec_chksum2});
    end

    always @(negedge CLK) begin
        if (done) done_cnt++;
        if ((dREN && rec_valid) || dWEN || (dstore != 0)) viol++;
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic rec_t mk(input logic l, input logic [15:0] i,
                                input logic [31:0] d, input logic [7:0] c);
        return {l, i, d, c};
    endfunction

    task automatic pulse_start();
        @(negedge CLK) start = 1'b1;
        @(negedge CLK) start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen = 0;
        for (int c = 0; c < 500 && !seen; c++) begin
            @(negedge CLK);
            if (done) seen = 1;
        end
        chk({name, "_done_seen"}, 64'(seen), 64'd1);
        repeat (2) @(negedge CLK);
    endtask

    task automatic check_recs(input string name, input int k);
        chk({name, "_count"}, 64'(got.size()), 64'(tbl[k].n));
        for (int i = 0; i < int'(tbl[k].n) && i < got.size(); i++)
            chk($sformatf("%s_rec%0d", name, i), 64'(got[i]),
                64'(tbl[k].exp[i]));
        chk({name, "_done_cnt"}, 64'(done_cnt), 64'd1);
        chk({name, "_idle"}, {62'd0, busy, dREN}, 64'd0);
    endtask

    task automatic run_vec(input int k);
        mem = tbl[k].mem;
        wait_n = int'(tbl[k].wait_n);
        rdy = 1'b1;
        got.delete();
        done_cnt = 0;
        pulse_start();
        wait_done($sformatf("vec%0d", k));
        check_recs($sformatf("vec%0d", k), k);
    endtask

    initial begin
        rec_t eofr;
        bit   hit;
        eofr = mk(1'b1, 16'h0, 32'h0, 8'hFF);

        tbl[0].mem = '{32'h340100F0, 32'h0, 32'h0, 32'h0};
        tbl[0].wait_n = 0; tbl[0].n = 2;
        tbl[0].exp = '{mk(0, 16'd0, 32'h340100F0, 8'hD7), eofr, 0, 0, 0};
        tbl[1].mem = '{32'h0, 32'd99, 32'h0, 32'h0};
        tbl[1].wait_n = 0; tbl[1].n = 2;
        tbl[1].exp = '{mk(0, 16'd1, 32'h00000063, 8'h98), eofr, 0, 0, 0};
        tbl[2] = tbl[0];
        tbl[2].wait_n = 5;
        tbl[3].mem = '{32'h0, 32'h0, 32'h0, 32'h0};
        tbl[3].wait_n = 0; tbl[3].n = 1;
        tbl[3].exp = '{eofr, 0, 0, 0, 0};
        tbl[4].mem = '{32'h0, 32'h0, 32'h0, 32'h80000001};
        tbl[4].wait_n = 2; tbl[4].n = 2;
        tbl[4].exp = '{mk(0, 16'd3, 32'h80000001, 8'h78), eofr, 0, 0, 0};
        tbl[5].mem = '{32'h1, 32'h2, 32'h0, 32'hFFFFFFFF};
        tbl[5].wait_n = 1; tbl[5].n = 4;
        tbl[5].exp = '{mk(0, 16'd0, 32'h1, 8'hFB),
                       mk(0, 16'd1, 32'h2, 8'hF9),
                       mk(0, 16'd3, 32'hFFFFFFFF, 8'hFD), eofr, 0};

        nRST = 1'b0; start = 1'b0; start2 = 1'b0; rdy = 1'b1;
        mem = '0;
        #12;
        chk("reset_ctrl", {58'd0, busy, done, dREN, rec_valid, rec_last,
            dWEN}, 64'd0);
        chk("reset_addr", 64'(daddr), 64'd0);
        chk("reset_rec", {rec_index, rec_data, rec_chksum}, 64'd0);
        @(negedge CLK) nRST = 1'b1;

        for (int k = 0; k < 6; k++) run_vec(k);

        // Consumer stall in EMIT.
        mem = tbl[0].mem; wait_n = 0; rdy = 1'b0;
        got.delete(); done_cnt = 0;
        pulse_start();
        hit = 0;
        for (int c = 0; c < 50 && !hit; c++) begin
            @(negedge CLK);
            if (rec_valid) hit = 1;
        end
        chk("stall_valid_seen", 64'(hit), 64'd1);
        for (int c = 0; c < 10; c++) begin
            @(negedge CLK);
            chk($sformatf("stall_hold%0d", c),
                {rec_valid, dREN, rec_last, rec_index, rec_data, rec_chksum},
                {3'b100, 16'd0, 32'h340100F0, 8'hD7});
        end
        rdy = 1'b1;
        wait_done("stall");
        check_recs("stall", 0);

        // Extra starts while busy must not restart or duplicate.
        mem = tbl[0].mem; wait_n = 5;
        got.delete(); done_cnt = 0;
        pulse_start();
        repeat (3) @(negedge CLK);
        pulse_start();
        repeat (8) @(negedge CLK);
        pulse_start();
        wait_done("restart");
        check_recs("restart", 0);

        // Asynchronous reset while reading index 2.
        mem = '0; wait_n = 5;
        pulse_start();
        hit = 0;
        for (int c = 0; c < 100 && !hit; c++) begin
            @(negedge CLK);
            if (dREN && daddr == 32'd8) hit = 1;
        end
        chk("rst_reach_idx2", 64'(hit), 64'd1);
        #2 nRST = 1'b0;
        #1 chk("rst_async", {60'd0, dREN, rec_valid, busy, done}, 64'd0);
        chk("rst_addr", 64'(daddr), 64'd0);
        @(negedge CLK) nRST = 1'b1;
        run_vec(0);

        // SKIP_ZERO=0, two words, all zero.
        got2.delete();
        @(negedge CLK) start2 = 1'b1;
        @(negedge CLK) start2 = 1'b0;
        hit = 0;
        for (int c = 0; c < 100 && !hit; c++) begin
            @(negedge CLK);
            if (done2) hit = 1;
        end
        chk("noskip_done_seen", 64'(hit), 64'd1);
        chk("noskip_count", 64'(got2.size()), 64'd3);
        if (got2.size() == 3) begin
            chk("noskip_rec0", 64'(got2[0]), 64'(mk(0, 16'd0, 32'h0, 8'hFC)));
            chk("noskip_rec1", 64'(got2[1]), 64'(mk(0, 16'd1, 32'h0, 8'hFB)));
            chk("noskip_eof", 64'(got2[2]), 64'(eofr));
        end

        chk("protocol_violations", 64'(viol), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
